// File: rtl/alu_issue_if.sv
// Issue-stage bus: decode-slot inputs, pipeline control and the EX register outputs.
// Latency: none (signal bundle only).
// Backpressure: stall/flush from the consumer side; id_ready reports acceptance.
// Ports: master drives id_*, rs*_data, stall, flush and observes id_ready/ex_*;
//        slave is the issue stage itself.
interface alu_issue_if;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        stall;
   logic        flush;
   logic        id_ready;
   logic        ex_valid;
   logic [3:0]  ex_ALU_operation;
   logic [31:0] ex_A;
   logic [31:0] ex_B;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_illegal;

   modport master (
      output id_valid, id_inst, id_pc, rs1_data, rs2_data, stall, flush,
      input  id_ready, ex_valid, ex_ALU_operation, ex_A, ex_B, ex_rd,
             ex_reg_write, ex_illegal
   );

   modport slave (
      input  id_valid, id_inst, id_pc, rs1_data, rs2_data, stall, flush,
      output id_ready, ex_valid, ex_ALU_operation, ex_A, ex_B, ex_rd,
             ex_reg_write, ex_illegal
   );
endinterface

// File: rtl/alu_issue.sv
// RV32I ALU issue stage: decodes id_inst into ALU op/operands and registers them as EX.
// Latency: 1 cycle from id_inst to ex_* outputs.
// Backpressure: stall holds EX, flush clears it (flush wins); id_ready = !stall || flush.
// Ports: clk, rst (sync, active-high); bus (alu_issue_if.slave) carries the decode
//        slot, register-file data, stall/flush and the registered ex_* fields.
module alu_issue (
   input logic       clk,
   input logic       rst,
   alu_issue_if.slave bus
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic        valid;
      logic [3:0]  alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
   } ex_t;

   // Cleared EX register contents, used for reset, flush and bubbles alike.
   localparam ex_t EX_IDLE = '{valid: 1'b0, alu_op: ALU_ADD, a: 32'd0, b: 32'd0,
                               rd: 5'd0, reg_write: 1'b0, illegal: 1'b0};

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_u;
   logic [31:0] shamt;
   logic [3:0]  f3_op;
   logic [3:0]  dec_op;
   logic [31:0] dec_a;
   logic [31:0] dec_b;
   logic        dec_rw;
   logic        dec_ill;
   ex_t         dec;
   ex_t         ex_q;

   assign opcode = bus.id_inst[6:0];
   assign funct3 = bus.id_inst[14:12];
   assign funct7 = bus.id_inst[31:25];
   assign rd     = bus.id_inst[11:7];
   assign imm_i  = {{20{bus.id_inst[31]}}, bus.id_inst[31:20]};
   assign imm_s  = {{20{bus.id_inst[31]}}, bus.id_inst[31:25], bus.id_inst[11:7]};
   assign imm_u  = {bus.id_inst[31:12], 12'b0};
   assign shamt  = {27'b0, bus.id_inst[24:20]};

   // Base op selected by funct3; the funct7 alternates are patched in below.
   always_comb begin
      f3_op = ALU_ADD;
      case (funct3)
         3'b000:  f3_op = ALU_ADD;
         3'b001:  f3_op = ALU_SLL;
         3'b010:  f3_op = ALU_SLT;
         3'b011:  f3_op = ALU_SLTU;
         3'b100:  f3_op = ALU_XOR;
         3'b101:  f3_op = ALU_SRL;
         3'b110:  f3_op = ALU_OR;
         default: f3_op = ALU_AND;
      endcase
   end

   always_comb begin
      dec_op  = ALU_ADD;
      dec_a   = 32'd0;
      dec_b   = 32'd0;
      dec_rw  = 1'b0;
      dec_ill = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_op = f3_op;
            dec_a  = bus.rs1_data;
            dec_b  = bus.rs2_data;
            dec_rw = 1'b1;
            // Only ADD/SUB and SRL/SRA have a funct7 alternate.
            if (funct3 == 3'b000 || funct3 == 3'b101) begin
               if (funct7 == F7_ALT)
                  dec_op = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
               else if (funct7 != F7_BASE)
                  dec_ill = 1'b1;
            end else if (funct7 != F7_BASE) begin
               dec_ill = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_op = f3_op;
            dec_a  = bus.rs1_data;
            dec_b  = imm_i;
            dec_rw = 1'b1;
            // Shift-immediates reuse imm[11:5] as funct7 and take only the shamt.
            if (funct3 == 3'b001) begin
               dec_b = shamt;
               if (funct7 != F7_BASE)
                  dec_ill = 1'b1;
            end else if (funct3 == 3'b101) begin
               dec_b = shamt;
               if (funct7 == F7_ALT)
                  dec_op = ALU_SRA;
               else if (funct7 != F7_BASE)
                  dec_ill = 1'b1;
            end
         end
         OPC_LUI: begin
            dec_b  = imm_u;
            dec_rw = 1'b1;
         end
         OPC_AUIPC: begin
            dec_a  = bus.id_pc;
            dec_b  = imm_u;
            dec_rw = 1'b1;
         end
         OPC_LOAD: begin
            dec_a  = bus.rs1_data;
            dec_b  = imm_i;
            dec_rw = 1'b1;
         end
         OPC_STORE: begin
            dec_a = bus.rs1_data;
            dec_b = imm_s;
         end
         OPC_BRANCH: begin
            dec_op = ALU_SUB;
            dec_a  = bus.rs1_data;
            dec_b  = bus.rs2_data;
         end
         OPC_JAL, OPC_JALR: begin
            // ALU computes the link address pc+4.
            dec_a  = bus.id_pc;
            dec_b  = 32'd4;
            dec_rw = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_op = ALU_ADD;
         dec_a  = 32'd0;
         dec_b  = 32'd0;
         dec_rw = 1'b0;
      end
   end

   always_comb begin
      dec.valid     = 1'b1;
      dec.alu_op    = dec_op;
      dec.a         = dec_a;
      dec.b         = dec_b;
      dec.rd        = rd;
      dec.reg_write = dec_rw && (rd != 5'd0);
      dec.illegal   = dec_ill;
   end

   always_ff @(posedge clk) begin
      if (rst)
         ex_q <= EX_IDLE;
      else if (bus.flush)
         ex_q <= EX_IDLE;
      else if (!bus.stall)
         ex_q <= bus.id_valid ? dec : EX_IDLE;
   end

   assign bus.id_ready         = !bus.stall || bus.flush;
   assign bus.ex_valid         = ex_q.valid;
   assign bus.ex_ALU_operation = ex_q.alu_op;
   assign bus.ex_A             = ex_q.a;
   assign bus.ex_B             = ex_q.b;
   assign bus.ex_rd            = ex_q.rd;
   assign bus.ex_reg_write     = ex_q.reg_write;
   assign bus.ex_illegal       = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SRA = 4'd7, AND_OP = 4'd9;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu_issue_if bus ();

   alu_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // {valid, op, A, B, rd, reg_write, illegal}
   logic [75:0] ex_obs;
   assign ex_obs = {bus.ex_valid, bus.ex_ALU_operation, bus.ex_A, bus.ex_B,
                    bus.ex_rd, bus.ex_reg_write, bus.ex_illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
      bus.id_valid = v;
      bus.id_inst  = inst;
      bus.id_pc    = pc;
      bus.rs1_data = r1;
      bus.rs2_data = r2;
   endtask

   task automatic test_reset;
      logic [75:0] exp;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(1'b1, 32'h007302B3, 32'h0, 32'd1, 32'd2);
      tick();
      exp = {1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (ex_obs !== exp) begin
         errors++;
         $display("FAIL reset_state got=%h want=%h", ex_obs, exp);
      end
      checks++;
      if (bus.id_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_in_reset got=%b want=1", bus.id_ready);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_id_ready;
      logic [2:0] exp;
      logic [2:0] obs;
      bus.stall = 1'b1; bus.flush = 1'b0; #1; obs[2] = bus.id_ready;
      bus.stall = 1'b1; bus.flush = 1'b1; #1; obs[1] = bus.id_ready;
      bus.stall = 1'b0; bus.flush = 1'b1; #1; obs[0] = bus.id_ready;
      bus.flush = 1'b0;
      exp = 3'b011;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL id_ready got=%b want=%b", obs, exp);
      end
   endtask

   task automatic test_decode;
      logic [31:0] inst_t [13];
      logic [31:0] pc_t   [13];
      logic [31:0] r1_t   [13];
      logic [31:0] r2_t   [13];
      logic [75:0] exp_t  [13];
      inst_t[0]  = 32'h40208033; pc_t[0]  = 32'h0;   r1_t[0]  = 32'd5;         r2_t[0]  = 32'd3;
      exp_t[0]   = {1'b1, SUB, 32'd5, 32'd3, 5'd0, 1'b0, 1'b0};
      inst_t[1]  = 32'h4051D193; pc_t[1]  = 32'h0;   r1_t[1]  = 32'h80000000;  r2_t[1]  = 32'd9;
      exp_t[1]   = {1'b1, SRA, 32'h80000000, 32'd5, 5'd3, 1'b1, 1'b0};
      inst_t[2]  = 32'h12345097; pc_t[2]  = 32'h100; r1_t[2]  = 32'd7;         r2_t[2]  = 32'd8;
      exp_t[2]   = {1'b1, ADD, 32'h100, 32'h12345000, 5'd1, 1'b1, 1'b0};
      inst_t[3]  = 32'hABCDE137; pc_t[3]  = 32'h40;  r1_t[3]  = 32'd7;         r2_t[3]  = 32'd8;
      exp_t[3]   = {1'b1, ADD, 32'd0, 32'hABCDE000, 5'd2, 1'b1, 1'b0};
      inst_t[4]  = 32'hFE50AE23; pc_t[4]  = 32'h0;   r1_t[4]  = 32'h1000;      r2_t[4]  = 32'd1;
      exp_t[4]   = {1'b1, ADD, 32'h1000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0};
      inst_t[5]  = 32'h00208063; pc_t[5]  = 32'h0;   r1_t[5]  = 32'd7;         r2_t[5]  = 32'd9;
      exp_t[5]   = {1'b1, SUB, 32'd7, 32'd9, 5'd0, 1'b0, 1'b0};
      inst_t[6]  = 32'h000000EF; pc_t[6]  = 32'h200; r1_t[6]  = 32'd7;         r2_t[6]  = 32'd9;
      exp_t[6]   = {1'b1, ADD, 32'h200, 32'd4, 5'd1, 1'b1, 1'b0};
      inst_t[7]  = 32'hFFF00093; pc_t[7]  = 32'h0;   r1_t[7]  = 32'h55;        r2_t[7]  = 32'd9;
      exp_t[7]   = {1'b1, ADD, 32'h55, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0};
      inst_t[8]  = 32'h0020F233; pc_t[8]  = 32'h0;   r1_t[8]  = 32'hF0F0;      r2_t[8]  = 32'hFF00;
      exp_t[8]   = {1'b1, AND_OP, 32'hF0F0, 32'hFF00, 5'd4, 1'b1, 1'b0};
      inst_t[9]  = 32'hFFFFFFFF; pc_t[9]  = 32'h80;  r1_t[9]  = 32'd3;         r2_t[9]  = 32'd4;
      exp_t[9]   = {1'b1, ADD, 32'd0, 32'd0, 5'd31, 1'b0, 1'b1};
      inst_t[10] = 32'h02208033; pc_t[10] = 32'h0;   r1_t[10] = 32'd3;         r2_t[10] = 32'd4;
      exp_t[10]  = {1'b1, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
      inst_t[11] = 32'h40109093; pc_t[11] = 32'h0;   r1_t[11] = 32'd3;         r2_t[11] = 32'd4;
      exp_t[11]  = {1'b1, ADD, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1};
      inst_t[12] = 32'h007302B3; pc_t[12] = 32'h0;   r1_t[12] = 32'd10;        r2_t[12] = 32'd20;
      exp_t[12]  = {1'b1, ADD, 32'd10, 32'd20, 5'd5, 1'b1, 1'b0};
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, inst_t[i], pc_t[i], r1_t[i], r2_t[i]);
         tick();
         checks++;
         if (ex_obs !== exp_t[i]) begin
            errors++;
            $display("FAIL decode[%0d] inst=%h got=%h want=%h", i, inst_t[i], ex_obs, exp_t[i]);
         end
      end
   endtask

   task automatic test_bubble;
      logic [75:0] exp;
      drive(1'b0, 32'h007302B3, 32'h0, 32'd10, 32'd20);
      tick();
      exp = {1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (ex_obs !== exp) begin
         errors++;
         $display("FAIL bubble got=%h want=%h", ex_obs, exp);
      end
   endtask

   task automatic test_stall_flush;
      logic [75:0] exp;
      drive(1'b1, 32'h007302B3, 32'h0, 32'd10, 32'd20);
      tick();
      exp = {1'b1, ADD, 32'd10, 32'd20, 5'd5, 1'b1, 1'b0};
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40208033 + 32'(i << 7), 32'h0, 32'd99 + 32'(i), 32'd1);
         tick();
         checks++;
         if (ex_obs !== exp) begin
            errors++;
            $display("FAIL stall_hold[%0d] got=%h want=%h", i, ex_obs, exp);
         end
      end
      bus.flush = 1'b1;
      drive(1'b1, 32'h12345097, 32'h100, 32'd1, 32'd1);
      tick();
      exp = {1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (ex_obs !== exp) begin
         errors++;
         $display("FAIL stall_flush got=%h want=%h", ex_obs, exp);
      end
      bus.stall = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic test_flush_illegal;
      logic [75:0] exp;
      drive(1'b1, 32'hFFFFFFFF, 32'h0, 32'd1, 32'd2);
      tick();
      bus.flush = 1'b1;
      drive(1'b1, 32'h007302B3, 32'h0, 32'd1, 32'd2);
      tick();
      bus.flush = 1'b0;
      exp = {1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (ex_obs !== exp) begin
         errors++;
         $display("FAIL flush_clears got=%h want=%h", ex_obs, exp);
      end
   endtask

   task automatic test_reset_mid_stall;
      logic [75:0] exp;
      drive(1'b1, 32'h12345097, 32'h300, 32'd0, 32'd0);
      tick();
      bus.stall = 1'b1;
      rst = 1'b1;
      tick();
      exp = {1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (ex_obs !== exp) begin
         errors++;
         $display("FAIL reset_mid_stall got=%h want=%h", ex_obs, exp);
      end
      rst = 1'b0;
      bus.stall = 1'b0;
      drive(1'b1, 32'h0020F233, 32'h0, 32'h1234, 32'h00FF);
      tick();
      exp = {1'b1, AND_OP, 32'h1234, 32'h00FF, 5'd4, 1'b1, 1'b0};
      checks++;
      if (ex_obs !== exp) begin
         errors++;
         $display("FAIL load_after_reset got=%h want=%h", ex_obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_id_ready();
      test_decode();
      test_bubble();
      test_stall_flush();
      test_flush_illegal();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst; all state SHALL update on the rising edge of clk only.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 id_valid  in  1  decode slot holds a real instruction.
REQ-005 id_inst  in  32  RV32I instruction word.
REQ-006 id_pc  in  32  PC of id_inst.
REQ-007 rs1_data, rs2_data  in  32 each  register-file read data.
REQ-008 stall  in  1  hold the EX register.
REQ-009 flush  in  1  squash the EX register.
REQ-010 id_ready  out  1  issue stage accepts id_inst this cycle.
REQ-011 ex_valid  out  1  EX register holds a real instruction.
REQ-012 ex_ALU_operation  out  4  ALU op code, using the shared ALU_* encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
REQ-013 ex_A, ex_B  out  32 each  ALU operands.
REQ-014 ex_rd  out  5  destination register index.
REQ-015 ex_reg_write  out  1  the EX result is written back.
REQ-016 ex_illegal  out  1  the issued instruction was not decodable.

Function
REQ-017 Decode SHALL be combinational from id_inst; the results SHALL be registered into ex_* with 1-cycle latency.
REQ-018 Opcode 0110011 (OP) SHALL map funct3/funct7 {000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND}; A=rs1_data, B=rs2_data; any other funct7 is illegal.
REQ-019 Opcode 0010011 (OP-IMM) SHALL use the same funct3 mapping with A=rs1_data and B=sign-extended imm[11:0]; SLLI requires funct7=0000000, and SRLI/SRAI require funct7 0000000/0100000, otherwise the instruction is illegal; shifts SHALL use B={27'b0,shamt}.
REQ-020 LUI (0110111): ADD, A=0, B={inst[31:12],12'b0}. AUIPC (0010111): ADD, A=id_pc, B=same immediate.
REQ-021 LOAD (0000011) and STORE (0100011): ADD, A=rs1_data, B=sign-extended I-type or S-type imm; STORE sets reg_write=0.
REQ-022 BRANCH (1100011): SUB, A=rs1_data, B=rs2_data, reg_write=0. JAL/JALR (1101111/1100111): ADD, A=id_pc, B=4, reg_write=1.
REQ-023 Any other opcode, or an illegal funct, SHALL issue with illegal=1, ALU op ADD, A=B=0, and reg_write=0.
REQ-024 ex_reg_write SHALL be 0 whenever rd==0, ex_valid==0, or illegal==1.
REQ-025 id_ready SHALL equal !stall || flush.
REQ-026 Register update priority SHALL be, highest first: rst > flush > stall > load.
REQ-027 On flush, the next cycle SHALL show ex_valid=0, ex_reg_write=0, ex_illegal=0, with all other ex_* fields cleared to 0.
REQ-028 On stall without flush, all ex_* outputs SHALL hold their previous value.
REQ-029 On load with id_valid=0, the stage SHALL insert a bubble: ex_valid=0, ex_reg_write=0, ex_illegal=0, with other fields don't-care but deterministic (0).
REQ-030 On load with id_valid=1, ex_valid=1 and the decoded fields SHALL be captured.
REQ-031 When stall and flush are asserted in the same cycle, flush SHALL win, and id_inst SHALL NOT be captured in that cycle.
REQ-032 All arithmetic for operand formation SHALL be 32-bit with no overflow flagging.

Reset
REQ-033 rst=1 at a clock edge SHALL clear every ex_* output to 0, with ex_ALU_operation equal to the ALU_ADD code, regardless of stall or flush.
REQ-034 Reset asserted mid-stall SHALL discard the held instruction; the first load after rst deasserts SHALL proceed normally.
REQ-035 id_ready is combinational and SHALL be independent of rst.

Verification
REQ-036 Bench: id_inst=0x40208033 (sub x0,x1,x2), rs1=5, rs2=3 -> next cycle op=SUB, A=5, B=3, rd=0, reg_write=0, ex_valid=1.
REQ-037 Bench: id_inst=0x4051D193 (srai x3,x3,5), rs1=0x80000000 -> op=SRA, B=5, reg_write=1, illegal=0.
REQ-038 Bench: id_inst=0x12345097 (auipc x1), pc=0x100 -> op=ADD, A=0x100, B=0x12345000.
REQ-039 Bench: load a valid add, then stall=1 for 3 cycles while id_inst changes -> ex_* unchanged; stall=flush=1 -> ex_valid=0 next cycle.
REQ-040 Bench: id_inst=0xFFFFFFFF, id_valid=1 -> illegal=1, reg_write=0, op=ADD, A=B=0.
REQ-041 Bench: rst=1 together with stall=1 after a valid issue -> all ex_* outputs are 0 on the next edge.
